// File: rtl/udma_pkg.sv
// Shared uDMA datapath types plus the TX arbiter state encoding.
package udma_pkg;

   typedef logic [31:0] ch_addr_t;
   typedef logic [31:0] ch_data_t;
   typedef logic [1:0]  ch_datasize_t;
   typedef logic [1:0]  ch_dest_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } txarb_state_e;

endpackage

// File: rtl/udma_txarb_id_fifo.sv
// In-order FIFO of requester ids for reads granted but not yet returned.
// DEPTH must be a power of 2 and at least 2.
module udma_txarb_id_fifo #(
   parameter int ID_W  = 2,
   parameter int DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic [ID_W-1:0] id_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output logic [ID_W-1:0] head_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [ID_W-1:0] mem_q [DEPTH];
   logic [PTR_W:0]  wr_q, wr_d, rd_q, rd_d;
   logic            do_push, do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                    (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign head_o  = mem_q[rd_q[PTR_W-1:0]];

   always_comb begin
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
      rd_d    = do_pop  ? rd_q + PTR_ONE : rd_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q[PTR_W-1:0]] <= id_i;
      end
   end

endmodule

// File: rtl/udma_tx_ch_arbiter.sv
// Round-robin arbiter sharing one L2 read port among TX channels, with in-order return steering.
// Optional UDMA_TXARB_PRIO_EN adds ch_prio_i: flagged requesters win the round-robin when present.
module udma_tx_ch_arbiter
   import udma_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int MAX_OUTST = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N_CH-1:0]   ch_req_i,
   input  ch_addr_t          ch_addr_i     [N_CH],
   input  ch_datasize_t      ch_datasize_i [N_CH],
   input  ch_dest_t          ch_dest_i     [N_CH],
   output logic [N_CH-1:0]   ch_gnt_o,
   output logic [N_CH-1:0]   ch_valid_o,
   output ch_data_t          ch_data_o,
   input  logic [N_CH-1:0]   ch_ready_i,
   output logic              mem_req_o,
   output ch_addr_t          mem_addr_o,
   output ch_datasize_t      mem_datasize_o,
   output ch_dest_t          mem_dest_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  ch_data_t          mem_rdata_i,
   output logic              mem_rready_o,
   output logic              busy_o,
   output logic              err_o
`ifdef UDMA_TXARB_PRIO_EN
   ,
   input  logic [N_CH-1:0]   ch_prio_i
`endif
);

   localparam int ID_W = $clog2(N_CH);
   localparam logic [ID_W-1:0] LAST_CH = ID_W'(N_CH - 1);

   txarb_state_e    state_q, state_d;
   logic [ID_W-1:0] rr_q, rr_d, lock_q, lock_d;
   logic            err_q, err_d;
   logic [N_CH-1:0] cand;
   logic [ID_W-1:0] idx, pick, sel, head;
   logic            found, req, push, pop, fifo_full, fifo_empty;

   always_comb begin
      cand = ch_req_i;
`ifdef UDMA_TXARB_PRIO_EN
      if (|(ch_req_i & ch_prio_i)) begin
         cand = ch_req_i & ch_prio_i;
      end
`endif
   end

   // First candidate at or after the rr pointer, wrapping around.
   always_comb begin
      pick  = rr_q;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         idx = ID_W'((int'(rr_q) + k) % N_CH);
         if (!found && cand[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      lock_d   = lock_q;
      sel      = pick;
      req      = 1'b0;
      push     = 1'b0;
      ch_gnt_o = '0;
      case (state_q)
         IDLE:    req = (|ch_req_i) & ~fifo_full;
         LOCKED: begin
            sel = lock_q;
            req = 1'b1;
         end
         default: req = 1'b0;
      endcase
      if (req && mem_gnt_i) begin
         ch_gnt_o[sel] = 1'b1;
         push          = 1'b1;
         rr_d          = (sel == LAST_CH) ? '0 : sel + 1'b1;
         state_d       = IDLE;
      end else if (req) begin
         state_d = LOCKED;
         lock_d  = sel;
      end
   end

   assign mem_req_o      = req;
   assign mem_addr_o     = req ? ch_addr_i[sel]     : '0;
   assign mem_datasize_o = req ? ch_datasize_i[sel] : '0;
   assign mem_dest_o     = req ? ch_dest_i[sel]     : '0;

   // A return with nothing outstanding is still accepted so the L2 side never stalls.
   always_comb begin
      ch_valid_o   = '0;
      mem_rready_o = mem_rvalid_i;
      if (!fifo_empty) begin
         ch_valid_o[head] = mem_rvalid_i;
         mem_rready_o     = ch_ready_i[head];
      end
   end

   assign ch_data_o = mem_rdata_i;
   assign pop       = mem_rvalid_i & mem_rready_o & ~fifo_empty;
   assign err_d     = err_q | (mem_rvalid_i & fifo_empty);
   assign err_o     = err_q;
   assign busy_o    = ~fifo_empty | (state_q == LOCKED) | req;

   udma_txarb_id_fifo #(
      .ID_W  (ID_W),
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .id_i    (sel),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rr_q    <= '0;
         lock_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_udma_tx_ch_arbiter.sv
// Bench for udma_tx_ch_arbiter: directed scenarios plus a randomized run checked against
// a queue-based model of outstanding reads.
module tb_udma_tx_ch_arbiter;
   import udma_pkg::*;

   localparam int N_CH      = 4;
   localparam int MAX_OUTST = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N_CH-1:0] ch_req, ch_gnt, ch_valid, ch_ready, last_gnt;
   ch_addr_t        ch_addr [N_CH];
   ch_datasize_t    ch_ds   [N_CH];
   ch_dest_t        ch_dest [N_CH];
   ch_data_t        ch_data, mem_rdata;
   logic            mem_req, mem_gnt, mem_rvalid, mem_rready, busy, err;
   ch_addr_t        mem_addr;
   ch_datasize_t    mem_ds;
   ch_dest_t        mem_dest;
`ifdef UDMA_TXARB_PRIO_EN
   logic [N_CH-1:0] ch_prio = '0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: outstanding ids in issue order, rr pointer, pending (held) request.
   int              m_q[$];
   int              m_rr;
   int              m_lock;
   bit              m_err;
   int              exp_sel;
   bit              exp_req, exp_push, exp_pop, exp_rready, exp_busy, exp_err_next;
   logic [N_CH-1:0] exp_gnt, exp_valid;
   ch_addr_t        exp_addr;
   ch_datasize_t    exp_ds;
   ch_dest_t        exp_dest;

   always #5 clk = ~clk;

   udma_tx_ch_arbiter #(
      .N_CH      (N_CH),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ch_req_i       (ch_req),
      .ch_addr_i      (ch_addr),
      .ch_datasize_i  (ch_ds),
      .ch_dest_i      (ch_dest),
      .ch_gnt_o       (ch_gnt),
      .ch_valid_o     (ch_valid),
      .ch_data_o      (ch_data),
      .ch_ready_i     (ch_ready),
      .mem_req_o      (mem_req),
      .mem_addr_o     (mem_addr),
      .mem_datasize_o (mem_ds),
      .mem_dest_o     (mem_dest),
      .mem_gnt_i      (mem_gnt),
      .mem_rvalid_i   (mem_rvalid),
      .mem_rdata_i    (mem_rdata),
      .mem_rready_o   (mem_rready),
      .busy_o         (busy),
      .err_o          (err)
`ifdef UDMA_TXARB_PRIO_EN
      ,
      .ch_prio_i      (ch_prio)
`endif
   );

   task automatic model_reset();
      m_q.delete();
      m_rr   = 0;
      m_lock = -1;
      m_err  = 1'b0;
   endtask

   task automatic model_eval();
      logic [N_CH-1:0] cand;
      int              ch;
      cand = ch_req;
`ifdef UDMA_TXARB_PRIO_EN
      if ((ch_req & ch_prio) != '0) cand = ch_req & ch_prio;
`endif
      exp_sel = 0;
      if (m_lock >= 0) begin
         exp_sel = m_lock;
      end else begin
         for (int k = N_CH - 1; k >= 0; k--) begin
            ch = (m_rr + k) % N_CH;
            if (cand[ch]) exp_sel = ch;
         end
      end
      exp_req  = (m_lock >= 0) || ((ch_req != '0) && (m_q.size() < MAX_OUTST));
      exp_push = exp_req && mem_gnt;
      exp_gnt  = exp_push ? (N_CH'(1) << exp_sel) : '0;
      exp_addr = exp_req ? ch_addr[exp_sel] : '0;
      exp_ds   = exp_req ? ch_ds[exp_sel]   : '0;
      exp_dest = exp_req ? ch_dest[exp_sel] : '0;
      if (m_q.size() > 0) begin
         exp_valid    = mem_rvalid ? (N_CH'(1) << m_q[0]) : '0;
         exp_rready   = ch_ready[m_q[0]];
         exp_pop      = mem_rvalid && ch_ready[m_q[0]];
         exp_err_next = m_err;
      end else begin
         exp_valid    = '0;
         exp_rready   = mem_rvalid;
         exp_pop      = 1'b0;
         exp_err_next = m_err | mem_rvalid;
      end
      exp_busy = (m_q.size() > 0) || (m_lock >= 0) || exp_req;
   endtask

   task automatic model_commit();
      if (exp_pop) void'(m_q.pop_front());
      m_err = exp_err_next;
      if (exp_push) begin
         m_q.push_back(exp_sel);
         m_rr   = (exp_sel + 1) % N_CH;
         m_lock = -1;
      end else if (exp_req) begin
         m_lock = exp_sel;
      end
   endtask

   // Close the current cycle: advance the model with this cycle's inputs, then the clock.
   task automatic step();
      model_eval();
      if (rst) model_reset();
      else     model_commit();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ch_req     = '0;
      ch_ready   = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_addr[i] = '0;
         ch_ds[i]   = '0;
         ch_dest[i] = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
      n_cmp++; if (ch_gnt !== '0) begin n_bad++; $display("FAIL rst_gnt got %b want 0000", ch_gnt); end
      n_cmp++; if (ch_valid !== '0) begin n_bad++; $display("FAIL rst_valid got %b want 0000", ch_valid); end
      n_cmp++; if (mem_rready !== 1'b0) begin n_bad++; $display("FAIL rst_rready got %b want 0", mem_rready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
      n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
      $display("test_reset done");
   endtask

   task automatic test_single();
      ch_data_t word;
      ch_req     = 4'b0010;
      ch_addr[1] = 32'h1C00_0100;
      ch_dest[1] = 2'd3;
      mem_gnt    = 1'b1;
      #1;
      n_cmp++; if (ch_gnt !== 4'b0010) begin n_bad++; $display("FAIL t1_gnt got %b want 0010", ch_gnt); end
      n_cmp++; if (mem_addr !== 32'h1C00_0100) begin n_bad++; $display("FAIL t1_addr got %h want 1c000100", mem_addr); end
      n_cmp++; if (mem_dest !== 2'd3) begin n_bad++; $display("FAIL t1_dest got %0d want 3", mem_dest); end
      step();
      word       = $urandom;
      ch_req     = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      ch_ready   = 4'b0010;
      #1;
      n_cmp++; if (ch_valid !== 4'b0010) begin n_bad++; $display("FAIL t1_valid got %b want 0010", ch_valid); end
      n_cmp++; if (ch_data !== word) begin n_bad++; $display("FAIL t1_data got %h want %h", ch_data, word); end
      n_cmp++; if (mem_rready !== 1'b1) begin n_bad++; $display("FAIL t1_rready got %b want 1", mem_rready); end
      step();
      mem_rvalid = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy got %b want 0", busy); end
      $display("test_single done");
   endtask

   task automatic test_rr_order();
      int seq[5];
      seq = '{0, 1, 2, 3, 0};
      do_reset();
      ch_req   = '1;
      mem_gnt  = 1'b1;
      ch_ready = '1;
      for (int c = 0; c < 6; c++) begin
         mem_rvalid = (c > 0);
         mem_rdata  = 32'hD000_0000 + 32'(c);
         if (c == 5) ch_req = '0;
         #1;
         if (c < 5) begin
            n_cmp++; if (ch_gnt !== (N_CH'(1) << seq[c])) begin n_bad++; $display("FAIL t2_gnt c%0d got %b want ch%0d", c, ch_gnt, seq[c]); end
         end
         if (c > 0) begin
            n_cmp++; if (ch_valid !== (N_CH'(1) << seq[c-1])) begin n_bad++; $display("FAIL t2_valid c%0d got %b want ch%0d", c, ch_valid, seq[c-1]); end
         end
         step();
      end
      mem_rvalid = 1'b0;
      $display("test_rr_order done");
   endtask

   task automatic test_locked();
      do_reset();
      ch_req     = 4'b0100;
      ch_addr[2] = 32'h1C00_2220;
      mem_gnt    = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL t3_req got %b want 1", mem_req); end
      step();
      ch_req     = 4'b0101;
      ch_addr[0] = 32'h1C00_0000;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (mem_addr !== 32'h1C00_2220) begin n_bad++; $display("FAIL t3_hold c%0d got %h want 1c002220", c, mem_addr); end
         step();
      end
      mem_gnt = 1'b1;
      #1;
      n_cmp++; if (ch_gnt !== 4'b0100) begin n_bad++; $display("FAIL t3_gnt_first got %b want 0100", ch_gnt); end
      step();
      ch_req = 4'b0001;
      #1;
      n_cmp++; if (ch_gnt !== 4'b0001) begin n_bad++; $display("FAIL t3_gnt_second got %b want 0001", ch_gnt); end
      n_cmp++; if (mem_addr !== 32'h1C00_0000) begin n_bad++; $display("FAIL t3_addr_second got %h want 1c000000", mem_addr); end
      step();
      $display("test_locked done");
   endtask

   task automatic test_full();
      do_reset();
      ch_req  = 4'b0011;
      mem_gnt = 1'b1;
      step();
      ch_req = 4'b0010;
      step();
      ch_req = 4'b0001;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL t4_full_req got %b want 0", mem_req); end
      n_cmp++; if (ch_gnt !== '0) begin n_bad++; $display("FAIL t4_full_gnt got %b want 0000", ch_gnt); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t4_busy got %b want 1", busy); end
      step();
      mem_rvalid = 1'b1;
      ch_ready   = '1;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL t4_no_bypass got %b want 0", mem_req); end
      n_cmp++; if (ch_valid !== 4'b0001) begin n_bad++; $display("FAIL t4_head got %b want 0001", ch_valid); end
      step();
      mem_rvalid = 1'b0;
      #1;
      n_cmp++; if (ch_gnt !== 4'b0001) begin n_bad++; $display("FAIL t4_reassert got %b want 0001", ch_gnt); end
      step();
      $display("test_full done");
   endtask

   task automatic test_backpressure();
      ch_data_t word;
      do_reset();
      ch_req  = 4'b1000;
      mem_gnt = 1'b1;
      step();
      word       = $urandom;
      ch_req     = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = word;
      ch_ready   = 4'b0111;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_cmp++; if (mem_rready !== 1'b0) begin n_bad++; $display("FAIL t5_rready c%0d got %b want 0", c, mem_rready); end
         n_cmp++; if (ch_valid !== 4'b1000) begin n_bad++; $display("FAIL t5_valid c%0d got %b want 1000", c, ch_valid); end
         n_cmp++; if (ch_data !== word) begin n_bad++; $display("FAIL t5_data c%0d got %h want %h", c, ch_data, word); end
         step();
      end
      ch_ready = '1;
      #1;
      n_cmp++; if (mem_rready !== 1'b1) begin n_bad++; $display("FAIL t5_release got %b want 1", mem_rready); end
      step();
      mem_rvalid = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t5_drained got %b want 0", busy); end
      $display("test_backpressure done");
   endtask

   task automatic test_err();
      do_reset();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_0001;
      #1;
      n_cmp++; if (mem_rready !== 1'b1) begin n_bad++; $display("FAIL t6_rready got %b want 1", mem_rready); end
      n_cmp++; if (ch_valid !== '0) begin n_bad++; $display("FAIL t6_valid got %b want 0000", ch_valid); end
      step();
      mem_rvalid = 1'b0;
      step();
      step();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_sticky got %b want 1", err); end
      rst = 1'b1;
      step();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t6_clear got %b want 0", err); end
      n_cmp++; if ({mem_req, ch_gnt, ch_valid, mem_rready, busy} !== '0) begin n_bad++; $display("FAIL t6_outs got %b want 0", {mem_req, ch_gnt, ch_valid, mem_rready, busy}); end
      rst = 1'b0;
      step();
      $display("test_err done");
   endtask

   task automatic test_random();
      do_reset();
      last_gnt = '0;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (last_gnt[i]) ch_req[i] = 1'b0;
            if (!ch_req[i] && $urandom_range(2) == 0) begin
               ch_req[i]  = 1'b1;
               ch_addr[i] = $urandom;
               ch_ds[i]   = 2'($urandom);
               ch_dest[i] = 2'($urandom);
            end
         end
         mem_gnt    = ($urandom_range(3) != 0);
         mem_rvalid = (m_q.size() > 0) ? ($urandom_range(1) == 1) : ($urandom_range(80) == 0);
         mem_rdata  = $urandom;
         ch_ready   = N_CH'($urandom) | N_CH'($urandom);
`ifdef UDMA_TXARB_PRIO_EN
         ch_prio    = N_CH'($urandom) & N_CH'($urandom);
`endif
         #1;
         model_eval();
         n_cmp++; if (mem_req !== exp_req) begin n_bad++; $display("FAIL rnd_req c%0d got %b want %b", c, mem_req, exp_req); end
         n_cmp++; if (ch_gnt !== exp_gnt) begin n_bad++; $display("FAIL rnd_gnt c%0d got %b want %b", c, ch_gnt, exp_gnt); end
         n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_addr c%0d got %h want %h", c, mem_addr, exp_addr); end
         n_cmp++; if ({mem_ds, mem_dest} !== {exp_ds, exp_dest}) begin n_bad++; $display("FAIL rnd_ds_dest c%0d got %h want %h", c, {mem_ds, mem_dest}, {exp_ds, exp_dest}); end
         n_cmp++; if (ch_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", c, ch_valid, exp_valid); end
         n_cmp++; if (ch_data !== mem_rdata) begin n_bad++; $display("FAIL rnd_data c%0d got %h want %h", c, ch_data, mem_rdata); end
         n_cmp++; if (mem_rready !== exp_rready) begin n_bad++; $display("FAIL rnd_rready c%0d got %b want %b", c, mem_rready, exp_rready); end
         n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, exp_busy); end
         n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d got %b want %b", c, err, m_err); end
         if (exp_push) $display("grant ch%0d addr %h outstanding %0d", exp_sel, exp_addr, m_q.size());
         last_gnt = exp_gnt;
         step();
      end
      clear_inputs();
      $display("test_random done");
   endtask

   initial begin
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_rr_order();
      test_locked();
      test_full();
      test_backpressure();
      test_err();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
